// File: rtl/fft_unload_8bit_if.sv
// Handshake and data bundle between the FFT core outputs, the unloader and the serial sink.
// The DUT side uses the slave modport and the driving environment uses the master modport.
interface fft_unload_8bit_if #(
   parameter int WIDTH = 8
);
   logic             load;
   logic [WIDTH-1:0] in_0, in_1, in_2, in_3, in_4, in_5, in_6, in_7;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic [2:0]       out_index;
   logic             out_last;
   logic             busy;

   modport slave (
      input  load, in_0, in_1, in_2, in_3, in_4, in_5, in_6, in_7, out_ready,
      output out_data, out_valid, out_index, out_last, busy
   );

   modport master (
      output load, in_0, in_1, in_2, in_3, in_4, in_5, in_6, in_7, out_ready,
      input  out_data, out_valid, out_index, out_last, busy
   );
endinterface

// File: rtl/fft_unload_8bit.sv
// Parallel-in, serial-out unloader: captures eight FFT results at once and streams them
// over valid/ready. Optional bit-reversed read order restores natural frequency order.
module fft_unload_8bit #(
   parameter int WIDTH  = 8,
   parameter bit BITREV = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   fft_unload_8bit_if.slave   bus
);
   typedef enum logic {IDLE, SEND} state_e;

   state_e           state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic [WIDTH-1:0] mem_q [8];
   logic [WIDTH-1:0] mem_d [8];
   logic [WIDTH-1:0] in_w  [8];
   logic [2:0]       slot;
   logic             sending;
   logic             xfer;

   always_comb begin
      in_w[0] = bus.in_0;
      in_w[1] = bus.in_1;
      in_w[2] = bus.in_2;
      in_w[3] = bus.in_3;
      in_w[4] = bus.in_4;
      in_w[5] = bus.in_5;
      in_w[6] = bus.in_6;
      in_w[7] = bus.in_7;
   end

   // The beat counter walks the stream; slot maps a beat onto the buffer register it reads.
   assign slot    = BITREV ? {idx_q[0], idx_q[1], idx_q[2]} : idx_q;
   assign sending = (state_q == SEND);
   assign xfer    = sending && bus.out_ready;

   always_comb begin
      // NOTE: every signal gets its hold value first so no path through the case infers a latch.
      state_d = state_q;
      idx_d   = idx_q;
      mem_d   = mem_q;
      case (state_q)
         IDLE: begin
            if (bus.load) begin
               mem_d   = in_w;
               idx_d   = 3'd0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (xfer) begin
               if (idx_q == 3'd7) begin
                  idx_d   = 3'd0;
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= 3'd0;
         // NOTE: the buffer is cleared on reset so a discarded frame can never leak out later.
         for (int k = 0; k < 8; k++) mem_q[k] <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so all of them update together.
         state_q <= state_d;
         idx_q   <= idx_d;
         mem_q   <= mem_d;
      end
   end

   // Outputs depend on registered state only; nothing from out_ready or load reaches them.
   assign bus.out_valid = sending;
   assign bus.busy      = sending;
   assign bus.out_data  = sending ? mem_q[slot] : '0;
   assign bus.out_index = idx_q;
   assign bus.out_last  = sending && (idx_q == 3'd7);
endmodule

// File: doc/fft_unload_8bit.md
# fft_unload_8bit

Parallel-in, serial-out unloader for the 8-point FFT datapath, the output-side counterpart of the 8-stage input shift chain. It captures eight WIDTH-bit FFT results in a single cycle and then streams them out one sample per accepted beat over a valid/ready handshake. An optional bit-reversed read order restores natural frequency order from a decimation-in-time core. It sits between the FFT core outputs and the downstream serial sink (UART/SPI formatter).

## Interface
- WIDTH, 8, bits per sample
- BITREV, 0, read order: 0 = natural (in_0..in_7); 1 = bit-reversed index (0,4,2,6,1,5,3,7)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- load  in  1  capture request; sampled only when busy=0
- in_0 .. in_7  in  WIDTH each  parallel FFT results, sampled on accepted load
- out_data  out  WIDTH  current sample; 0 when out_valid=0
- out_valid  out  1  out_data holds a sample to transfer
- out_ready  in  1  sink accepts out_data this cycle
- out_index  out  3  position of the current beat in the stream (0..7), not the buffer slot
- out_last  out  1  high with out_valid on beat 7
- busy  out  1  high while a frame is held or streaming

## Operation
- Buffer: eight WIDTH-bit registers buf[0..7]; beat counter idx[2:0]; state IDLE or SEND.
- IDLE: busy=0, out_valid=0. If load=1: buf[k] <= in_k for all k, idx <= 0, go to SEND.
- SEND: busy=1, out_valid=1, out_data = buf[slot(idx)], where slot(idx)=idx for BITREV=0 and {idx[0],idx[1],idx[2]} for BITREV=1. out_index=idx, out_last=(idx==7).
- Transfer occurs when out_valid & out_ready. On a transfer with idx<7: idx <= idx+1. On a transfer with idx==7: go to IDLE, idx <= 0.
- When out_valid=1 and out_ready=0: idx, buf, out_data, out_index and out_last hold unchanged. Stalls may last any number of cycles.
- load during SEND is ignored, including in the cycle of the final transfer. Inputs are not re-sampled and buf is not disturbed.
- in_0..in_7 are don't-care outside the load-accept cycle.
- No arithmetic on data: samples pass through bit-exact, with no rounding, truncation or sign handling.
- Reset, highest priority (overrides load and transfers, including mid-frame):
  - state=IDLE, idx=0, buf all 0.
  - out_data=0, out_valid=0, out_index=0, out_last=0, busy=0.
  - A partially sent frame is discarded.

## Timing
- All outputs derive from registered state only. There is no combinational path from out_ready, load or in_k to any output.
- Load accepted at edge t: busy=1 and out_valid=1 with beat 0 visible after edge t (cycle t+1).
- With out_ready held high: beats 0..7 transfer on edges t+1..t+8. out_valid and busy return to 0 after edge t+8. The earliest next accepted load is sampled on edge t+9, giving 9 cycles per frame minimum.
- Each stall cycle (out_ready=0 while valid) adds exactly one cycle to the frame.
- load asserted on the cycle busy first reads 0 is accepted.

## Test plan
- Natural order, BITREV=0, in_k=8'h10+k, load one cycle, out_ready=1:
  - out_data 10,11,...,17 on 8 consecutive cycles starting one cycle after load.
  - out_index 0..7; out_last only on 17.
  - busy falls after the 8th beat.
- Bit-reversed order, BITREV=1, same inputs -> out_data 10,14,12,16,11,15,13,17.
- Backpressure: out_ready=0 for 3 cycles at beat 2, plus random toggling elsewhere:
  - beat 2 value and out_index=2 held stable during the stall.
  - no beat duplicated or dropped; frame lasts 8 + stall cycles.
- Load during SEND: reassert load with in_k=8'hA0+k at beat 4 and on the beat-7 cycle:
  - stream still finishes 10..17.
  - next frame starts only after a fresh load with busy=0.
- Reset mid-frame at beat 5:
  - next cycle all outputs 0, busy=0.
  - a following load of 8'h20+k streams 20..27 from beat 0.
- Back-to-back: load applied the first cycle busy=0 after a frame -> accepted; new frame's beat 0 appears one cycle later.
